// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the EX-stage control and the RV32M sequencer.
// Signal names carry the sequencer's (slave) point of view.
interface muldiv_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             i_start;
    logic [5:0]       i_select;
    logic [WIDTH-1:0] i_data1;
    logic [WIDTH-1:0] i_data2;
    logic [WIDTH-1:0] o_result;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_start, i_select, i_data1, i_data2,
        input  o_result, o_busy, o_done
    );

    modport slave (
        input  i_start, i_select, i_data1, i_data2,
        output o_result, o_busy, o_done
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: shift-add multiplier and restoring divider
// sharing one double-width working register, one iteration per cycle.
module muldiv_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input logic          i_clk,
    input logic          i_reset,
    muldiv_seq_if.slave  bus
);
    localparam int unsigned W2 = 2 * WIDTH;

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

    state_e           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic [W2-1:0]    r_work;
    logic [WIDTH-1:0] r_opnd;
    logic             r_neg;
    logic [WIDTH-1:0] r_result;

    logic [2:0]       w_op;
    logic             w_accept, w_is_div, w_s1_signed, w_s2_signed, w_sign1, w_sign2;
    logic [WIDTH-1:0] w_mag1, w_mag2, w_short_res;
    logic             w_div0, w_ovf, w_short, w_neg, w_last;

    assign w_op     = bus.i_select[2:0];
    assign w_is_div = w_op[2];
    assign w_accept = bus.i_start && (bus.i_select[5:3] == 3'b001) && (r_state != StCalc);

    assign w_s1_signed = (w_op == 3'b001) || (w_op == 3'b010) || (w_op == 3'b100) ||
                         (w_op == 3'b110);
    assign w_s2_signed = (w_op == 3'b001) || (w_op == 3'b100) || (w_op == 3'b110);
    assign w_sign1     = w_s1_signed && bus.i_data1[WIDTH-1];
    assign w_sign2     = w_s2_signed && bus.i_data2[WIDTH-1];
    assign w_mag1      = w_sign1 ? -bus.i_data1 : bus.i_data1;
    assign w_mag2      = w_sign2 ? -bus.i_data2 : bus.i_data2;

    // Divide-by-zero and signed overflow bypass the iteration entirely
    assign w_div0  = w_is_div && (bus.i_data2 == '0);
    assign w_ovf   = w_is_div && !w_op[0] && (bus.i_data1 == {1'b1, {(WIDTH-1){1'b0}}}) &&
                     (bus.i_data2 == '1);
    assign w_short = w_div0 || w_ovf;
    always_comb begin
        w_short_res = '0;
        if (w_op[1]) w_short_res = w_div0 ? bus.i_data1 : '0;
        else         w_short_res = w_div0 ? '1 : {1'b1, {(WIDTH-1){1'b0}}};
    end

    // Remainder follows the dividend's sign; everything else takes the product of signs
    assign w_neg  = (w_is_div && w_op[1]) ? w_sign1 : (w_sign1 ^ w_sign2);
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    logic [WIDTH:0]   w_sum, w_rem_sh;
    logic [W2-1:0]    w_mul_next, w_div_next, w_iter, w_prod_fix;
    logic [WIDTH-1:0] w_diff, w_qr, w_qr_fix, w_final;
    logic             w_ge;

    assign w_sum      = {1'b0, r_work[W2-1:WIDTH]} + (r_work[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_sum, r_work[WIDTH-1:1]};

    assign w_rem_sh   = {r_work[W2-1:WIDTH], r_work[WIDTH-1]};
    assign w_ge       = w_rem_sh >= {1'b0, r_opnd};
    assign w_diff     = w_rem_sh[WIDTH-1:0] - r_opnd;
    assign w_div_next = w_ge ? {w_diff, r_work[WIDTH-2:0], 1'b1}
                             : {w_rem_sh[WIDTH-1:0], r_work[WIDTH-2:0], 1'b0};

    assign w_iter     = r_op[2] ? w_div_next : w_mul_next;
    assign w_prod_fix = r_neg ? -w_iter : w_iter;
    assign w_qr       = r_op[1] ? w_iter[W2-1:WIDTH] : w_iter[WIDTH-1:0];
    assign w_qr_fix   = r_neg ? -w_qr : w_qr;
    assign w_final    = r_op[2] ? w_qr_fix :
                        (r_op[1:0] == 2'b00) ? w_prod_fix[WIDTH-1:0] : w_prod_fix[W2-1:WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= StIdle;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_next = w_short ? StFin : StCalc;
            StCalc:  if (w_last) w_state_next = StFin;
            StFin:   w_state_next = w_accept ? (w_short ? StFin : StCalc) : StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_work   <= '0;
            r_opnd   <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_op   <= w_op;
            r_neg  <= w_neg;
            // Low half holds the multiplier or the dividend; r_opnd the other operand
            r_opnd <= w_is_div ? w_mag2 : w_mag1;
            r_work <= {{WIDTH{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
            if (w_short) r_result <= w_short_res;
        end else if (r_state == StCalc) begin
            r_work <= w_iter;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) r_result <= w_final;
        end
    end

    assign bus.o_result = r_result;
    assign bus.o_busy   = (r_state == StCalc);
    assign bus.o_done   = (r_state == StFin);
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed and random checks of muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic rst;
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    muldiv_seq_if #(.WIDTH(32)) bus ();

    muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint     sa, sb, ub;
        logic [63:0] up, sp;
        logic        ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ub  = {32'b0, b};
        up  = {32'b0, a} * {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        sp  = '0;
        case (op)
            3'd0: return up[31:0];
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * ub; return sp[63:32]; end
            3'd3: return up[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                sp = sa / sb;
                return sp[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                sp = sa % sb;
                return sp[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (op[2] && (b == 0)) return 0;
        if (op[2] && !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 0;
        return 32;
    endfunction

    // Issues one request from the current cycle; leaves the bench in the DONE cycle
    // when linger is set so the next request lands back-to-back.
    task automatic run_op(input string tag, input logic [5:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit linger);
        int n, nb, lat;
        lat = ref_lat(sel[2:0], a, b);
        bus.i_start  = 1'b1;
        bus.i_select = sel;
        bus.i_data1  = a;
        bus.i_data2  = b;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        n  = 0;
        nb = 0;
        while (bus.o_done !== 1'b1 && n < 40) begin
            if (bus.o_busy === 1'b1) nb++;
            @(posedge clk); #1;
            n++;
        end
        check({tag, " done"}, 32'(bus.o_done), 32'd1);
        check({tag, " latency"}, 32'(n), 32'(lat));
        check({tag, " busy cycles"}, 32'(nb), 32'(lat));
        check({tag, " result"}, bus.o_result, exp);
        if (!linger) begin
            @(posedge clk); #1;
            check({tag, " done pulse"}, 32'(bus.o_done), 32'd0);
            check({tag, " idle busy"}, 32'(bus.o_busy), 32'd0);
            check({tag, " result held"}, bus.o_result, exp);
        end
    endtask

    initial begin
        int          n, pulses;
        logic [2:0]  op;
        logic [31:0] a, b;
        bit          lg;

        rst          = 1'b1;
        bus.i_start  = 1'b0;
        bus.i_select = '0;
        bus.i_data1  = '0;
        bus.i_data2  = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("reset result", bus.o_result, 32'h0);
        check("reset busy", 32'(bus.o_busy), 32'd0);
        check("reset done", 32'(bus.o_done), 32'd0);

        run_op("mul", 6'b001000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_op("mulh", 6'b001001, 32'hAAAA_AAAB, 32'h0002_FE7D, 32'hFFFF_0081, 1'b1);
        run_op("mulhu b2b", 6'b001011, 32'hAAAA_AAAB, 32'h0002_FE7D, 32'h0001_FEFE, 1'b1);
        run_op("mulhsu b2b", 6'b001010, 32'h8000_0000, 32'hFFFF_8000, 32'h8000_4000, 1'b0);
        run_op("div by 0", 6'b001100, 32'h0000_0007, 32'h0, 32'hFFFF_FFFF, 1'b0);
        run_op("remu by 0", 6'b001111, 32'h0000_0007, 32'h0, 32'h0000_0007, 1'b0);
        run_op("div ovf", 6'b001100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        run_op("rem ovf", 6'b001110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
        run_op("div neg", 6'b001100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        run_op("rem neg", 6'b001110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        run_op("divu", 6'b001101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0);

        // START while iterating must not disturb the operation in flight
        bus.i_start  = 1'b1;
        bus.i_select = 6'b001101;
        bus.i_data1  = 32'd1000;
        bus.i_data2  = 32'd7;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        bus.i_start = 1'b1;
        bus.i_data1 = 32'd5;
        bus.i_data2 = 32'd1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        n = 10;
        while (bus.o_done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        check("busy start latency", 32'(n), 32'd32);
        check("busy start result", bus.o_result, 32'd142);
        @(posedge clk); #1;

        bus.i_start  = 1'b1;
        bus.i_select = 6'b000000;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        check("bad sel busy", 32'(bus.o_busy), 32'd0);
        check("bad sel done", 32'(bus.o_done), 32'd0);
        check("bad sel result", bus.o_result, 32'd142);

        // Reset in the middle of a divide discards it
        bus.i_start  = 1'b1;
        bus.i_select = 6'b001100;
        bus.i_data1  = 32'd100;
        bus.i_data2  = 32'd3;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        repeat (15) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid reset busy", 32'(bus.o_busy), 32'd0);
        check("mid reset done", 32'(bus.o_done), 32'd0);
        check("mid reset result", bus.o_result, 32'h0);
        pulses = 0;
        repeat (40) begin
            if (bus.o_done === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        check("mid reset no done", 32'(pulses), 32'd0);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       b = 32'($urandom_range(1, 15));
                3:       a = 32'($urandom_range(0, 255));
                default: ;
            endcase
            lg = ($urandom_range(0, 3) == 0) && (i != 39);
            run_op("rnd", {3'b001, op}, a, b, ref_model(op, a, b), lg);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
